// File: rtl/lights_out_timer_pkg.sv
// Shared constants and helpers for the lights-out reaction timer.
package lights_out_timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Four-digit BCD increment with decimal carry; holds at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lights_out_timer_bcd.sv
// Four cascaded decade digits counting ms; saturates at 9999, clr beats en.
module bcd_counter4
  import lights_out_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next value: clear, increment with carry, or hold.
  always_comb begin
    q_d = q_q;
    if (clr)     q_d = 16'h0000;
    else if (en) q_d = bcd_inc(q_q);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 16'h0000;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/lights_out_timer.sv
// Delay responder for the start-light sequencer: random delay, then reaction timing in BCD ms.
module lights_out_timer
  import lights_out_timer_pkg::*;
#(
  parameter int LFSR_W       = 14,
  parameter int MIN_DELAY_MS = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start_delay,
  input  logic [LFSR_W-1:0] lfsr_value,
  input  logic              trigger,
  output logic              time_out,
  output logic [15:0]       reaction_bcd,
  output logic              reaction_valid,
  output logic              jump_start,
  output logic              busy
);

  localparam logic [LFSR_W-1:0] MIN_W = LFSR_W'(MIN_DELAY_MS);
  localparam logic [LFSR_W-1:0] ONE_W = LFSR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] cnt_q, cnt_d;
  logic              start_prev_q;
  logic              time_out_q, time_out_d;
  logic [15:0]       reaction_q, reaction_d;
  logic              valid_q, valid_d;
  logic              jump_q, jump_d;
  logic              busy_q;
  logic              bcd_clr, bcd_en;
  logic [15:0]       bcd_q;
  logic              start_rise;

  assign start_rise = start_delay & ~start_prev_q;

  bcd_counter4 u_bcd (
    .clk (clk),
    .rst (rst),
    .clr (bcd_clr),
    .en  (bcd_en),
    .q   (bcd_q)
  );

  // Sequencing: load delay on start edge, count ticks down, then time the reaction.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    time_out_d = time_out_q;
    reaction_d = reaction_q;
    valid_d    = 1'b0;
    jump_d     = jump_q;
    bcd_clr    = 1'b0;
    bcd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          cnt_d   = (lfsr_value < MIN_W) ? MIN_W : lfsr_value;
          jump_d  = 1'b0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort wins over an expiring tick in the same cycle.
        if (!start_delay) begin
          state_d = ST_IDLE;
        end else begin
          if (trigger) jump_d = 1'b1;
          if (tick) begin
            cnt_d = cnt_q - ONE_W;
            if (cnt_q == ONE_W) begin
              state_d    = ST_MEASURE;
              time_out_d = 1'b1;
              bcd_clr    = 1'b1;
            end
          end
        end
      end
      ST_MEASURE: begin
        bcd_en = tick;
        if (!start_delay) time_out_d = 1'b0;
        if (trigger) begin
          // Include a tick landing in the trigger cycle.
          reaction_d = tick ? bcd_inc(bcd_q) : bcd_q;
          valid_d    = 1'b1;
          time_out_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      time_out_q   <= 1'b0;
      reaction_q   <= 16'h0000;
      valid_q      <= 1'b0;
      jump_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_delay;
      time_out_q   <= time_out_d;
      reaction_q   <= reaction_d;
      valid_q      <= valid_d;
      jump_q       <= jump_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign time_out       = time_out_q;
  assign reaction_bcd   = reaction_q;
  assign reaction_valid = valid_q;
  assign jump_start     = jump_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lights_out_timer.sv
// Directed bench for lights_out_timer: delay floor, jump start, abort, saturation, reset.
module tb_lights_out_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start_delay;
  logic [13:0] lfsr_value;
  logic        trigger;
  logic        time_out;
  logic [15:0] reaction_bcd;
  logic        reaction_valid;
  logic        jump_start;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lights_out_timer #(.LFSR_W(14), .MIN_DELAY_MS(250)) dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .start_delay    (start_delay),
    .lfsr_value     (lfsr_value),
    .trigger        (trigger),
    .time_out       (time_out),
    .reaction_bcd   (reaction_bcd),
    .reaction_valid (reaction_valid),
    .jump_start     (jump_start),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given tick/trigger, sampled 1 time unit after the edge.
  task automatic drv(input logic t, input logic g);
    @(negedge clk);
    tick    = t;
    trigger = g;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b1, 1'b0);
      drv(1'b0, 1'b0);
    end
  endtask

  task automatic setsd(input logic v);
    @(negedge clk);
    tick        = 1'b0;
    trigger     = 1'b0;
    start_delay = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start_delay = 1'b0; lfsr_value = '0; trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_time_out", {15'd0, time_out}, 16'd0);
    chk("rst_reaction", reaction_bcd, 16'h0000);
    chk("rst_valid", {15'd0, reaction_valid}, 16'd0);
    chk("rst_jump", {15'd0, jump_start}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk); rst = 1'b0;

    // 1: 1000-tick delay, 237 ms reaction
    lfsr_value = 14'd1000;
    setsd(1'b1);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    ticks(999);
    chk("t1_to_before", {15'd0, time_out}, 16'd0);
    drv(1'b1, 1'b0);
    chk("t1_to_rise", {15'd0, time_out}, 16'd1);
    drv(1'b0, 1'b0);
    ticks(237);
    chk("t1_valid_pre", {15'd0, reaction_valid}, 16'd0);
    drv(1'b0, 1'b1);
    chk("t1_reaction", reaction_bcd, 16'h0237);
    chk("t1_valid", {15'd0, reaction_valid}, 16'd1);
    chk("t1_to_drop", {15'd0, time_out}, 16'd0);
    drv(1'b0, 1'b0);
    chk("t1_valid_once", {15'd0, reaction_valid}, 16'd0);
    ticks(5);
    chk("t1_hold_busy", {15'd0, busy}, 16'd0);
    chk("t1_hold_to", {15'd0, time_out}, 16'd0);

    // 2: lfsr below floor -> 250 ticks
    setsd(1'b0);
    lfsr_value = 14'd10;
    setsd(1'b1);
    ticks(249);
    chk("t2_to_249", {15'd0, time_out}, 16'd0);
    ticks(1);
    chk("t2_to_250", {15'd0, time_out}, 16'd1);
    drv(1'b0, 1'b1);
    chk("t2_reaction0", reaction_bcd, 16'h0000);
    chk("t2_valid", {15'd0, reaction_valid}, 16'd1);

    // 3: jump start at tick 40 of 500
    setsd(1'b0);
    lfsr_value = 14'd500;
    setsd(1'b1);
    chk("t3_jump_clr", {15'd0, jump_start}, 16'd0);
    ticks(40);
    drv(1'b0, 1'b1);
    drv(1'b0, 1'b0);
    chk("t3_jump_set", {15'd0, jump_start}, 16'd1);
    chk("t3_to_early", {15'd0, time_out}, 16'd0);
    ticks(459);
    chk("t3_to_499", {15'd0, time_out}, 16'd0);
    ticks(1);
    chk("t3_to_500", {15'd0, time_out}, 16'd1);
    chk("t3_jump_keep", {15'd0, jump_start}, 16'd1);
    drv(1'b0, 1'b1);
    chk("t3_jump_idle", {15'd0, jump_start}, 16'd1);

    // 4: abort at tick 100, no restart without an edge
    setsd(1'b0);
    lfsr_value = 14'd300;
    setsd(1'b1);
    chk("t4_jump_clr", {15'd0, jump_start}, 16'd0);
    chk("t4_busy", {15'd0, busy}, 16'd1);
    ticks(100);
    setsd(1'b0);
    chk("t4_abort_busy", {15'd0, busy}, 16'd0);
    ticks(300);
    chk("t4_abort_to", {15'd0, time_out}, 16'd0);
    chk("t4_abort_idle", {15'd0, busy}, 16'd0);
    setsd(1'b1);
    chk("t4_restart", {15'd0, busy}, 16'd1);

    // 5: saturation at 9999; time_out follows start_delay in MEASURE
    ticks(300);
    chk("t5_to", {15'd0, time_out}, 16'd1);
    setsd(1'b0);
    chk("t5_to_sd0", {15'd0, time_out}, 16'd0);
    chk("t5_busy", {15'd0, busy}, 16'd1);
    ticks(12000);
    chk("t5_hold_old", reaction_bcd, 16'h0000);
    drv(1'b0, 1'b1);
    chk("t5_sat", reaction_bcd, 16'h9999);
    chk("t5_valid", {15'd0, reaction_valid}, 16'd1);

    // 6: trigger with tick at 0099, then reset mid-COUNT
    lfsr_value = 14'd0;
    setsd(1'b1);
    ticks(249);
    chk("t6_to_249", {15'd0, time_out}, 16'd0);
    ticks(1);
    chk("t6_to_250", {15'd0, time_out}, 16'd1);
    ticks(99);
    drv(1'b1, 1'b1);
    chk("t6_same_cycle", reaction_bcd, 16'h0100);
    setsd(1'b0);
    lfsr_value = 14'd2000;
    setsd(1'b1);
    ticks(10);
    drv(1'b0, 1'b1);
    drv(1'b0, 1'b0);
    chk("t6_pre_jump", {15'd0, jump_start}, 16'd1);
    chk("t6_pre_busy", {15'd0, busy}, 16'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_jump", {15'd0, jump_start}, 16'd0);
    chk("t6_rst_reaction", reaction_bcd, 16'h0000);
    chk("t6_rst_to", {15'd0, time_out}, 16'd0);
    chk("t6_rst_valid", {15'd0, reaction_valid}, 16'd0);
    @(negedge clk); start_delay = 1'b0; rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
